// File: rtl/ls_issue_queue.sv
// In-order load/store issue queue: dispatch writes at tail, CDB wakeups set operand
// readiness, head issues under a ready handshake, recovered (killed) entries drain silently.
module ls_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 4,
  parameter int IMM_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       isDispatch,
  input  logic [ROB_W-1:0]           rob_num_dp,
  input  logic [PREG_W-1:0]          p_rd_new,
  input  logic [PREG_W-1:0]          p_rs,
  input  logic                       read_rs,
  input  logic                       v_rs,
  input  logic [PREG_W-1:0]          p_rt,
  input  logic                       read_rt,
  input  logic                       v_rt,
  input  logic                       mem_ren,
  input  logic                       mem_wen,
  input  logic [IMM_W-1:0]           immed,
  input  logic                       stall_hazard,
  input  logic                       issue_ready,
  input  logic                       recover,
  input  logic [ROB_W-1:0]           rob_num_rec,
  input  logic [PREG_W-1:0]          p_rd_compl,
  input  logic                       RegDest_compl,
  input  logic                       complete,
  output logic [PREG_W-1:0]          p_rs_out,
  output logic [PREG_W-1:0]          p_rt_out,
  output logic [PREG_W-1:0]          p_rd_out,
  output logic [IMM_W-1:0]           immed_out,
  output logic [ROB_W-1:0]           rob_num_out,
  output logic                       RegDest_out,
  output logic                       mem_ren_out,
  output logic                       mem_wen_out,
  output logic                       issue,
  output logic                       lss_full,
  output logic                       lss_empty,
  output logic [$clog2(DEPTH):0]     lss_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              valid;
    logic              killed;
    logic              is_lw;
    logic              is_st;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rs;
    logic              rdy_rs;
    logic [PREG_W-1:0] rt;
    logic              rdy_rt;
    logic [IMM_W-1:0]  imm;
  } entry_t;

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  entry_t           ent [DEPTH];
  entry_t           head_ent;
  entry_t           new_ent;
  logic             write_en;
  logic             drain_en;
  logic             pop_en;
  logic             wake_en;

  assign lss_full  = (count_reg == CNT_W'(DEPTH));
  assign lss_empty = (count_reg == '0);
  assign lss_count = count_reg;

  assign wake_en  = complete & RegDest_compl;
  assign write_en = isDispatch & ~stall_hazard & ~lss_full & ~recover & (mem_ren | mem_wen);
  assign head_ent = ent[head_reg];
  assign issue    = ~recover & ~stall_hazard & issue_ready & head_ent.valid & ~head_ent.killed
                  & head_ent.rdy_rs & head_ent.rdy_rt;
  // Killed heads leave without a handshake so recovery never waits on downstream.
  assign drain_en = head_ent.valid & head_ent.killed & ~recover;
  assign pop_en   = issue | drain_en;

  always_comb begin
    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.is_lw  = mem_ren;
    new_ent.is_st  = mem_wen;
    new_ent.rob    = rob_num_dp;
    new_ent.rd     = p_rd_new;
    new_ent.rs     = p_rs;
    new_ent.rt     = p_rt;
    new_ent.imm    = immed;
    // Same-cycle broadcast is folded in here, otherwise the wakeup would be lost.
    new_ent.rdy_rs = v_rs | ~read_rs | (wake_en & (p_rd_compl == p_rs));
    new_ent.rdy_rt = v_rt | ~read_rt | (wake_en & (p_rd_compl == p_rt));
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
      entry_t ent_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ent_reg <= '0;
        end else if (write_en && (tail_reg == IDX)) begin
          ent_reg <= new_ent;
        end else if (pop_en && (head_reg == IDX)) begin
          ent_reg <= '0;
        end else if (ent_reg.valid) begin
          if (wake_en && (ent_reg.rs == p_rd_compl)) ent_reg.rdy_rs <= 1'b1;
          if (wake_en && (ent_reg.rt == p_rd_compl)) ent_reg.rdy_rt <= 1'b1;
          if (recover && (ent_reg.rob == rob_num_rec)) begin
            ent_reg.killed <= 1'b1;
            ent_reg.is_lw  <= 1'b0;
            ent_reg.is_st  <= 1'b0;
          end
        end
      end

      assign ent[gi] = ent_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (write_en) tail_reg <= tail_reg + PTR_W'(1);
      if (pop_en)   head_reg <= head_reg + PTR_W'(1);
      case ({write_en, pop_en})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign p_rs_out    = head_ent.rs;
  assign p_rt_out    = head_ent.rt;
  assign p_rd_out    = head_ent.rd;
  assign immed_out   = head_ent.imm;
  assign rob_num_out = head_ent.rob;
  assign RegDest_out = head_ent.is_lw;
  assign mem_ren_out = head_ent.is_lw;
  assign mem_wen_out = head_ent.is_st;

endmodule

// File: tb/tb_ls_issue_queue.sv
// Scoreboarded random + directed bench for ls_issue_queue against a queue-level model.
module tb_ls_issue_queue;
  localparam int DEPTH = 8, PREG_W = 6, ROB_W = 4, IMM_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic isDispatch = 0, read_rs = 0, v_rs = 0, read_rt = 0, v_rt = 0;
  logic mem_ren = 0, mem_wen = 0, stall_hazard = 0, issue_ready = 0;
  logic recover = 0, RegDest_compl = 0, complete = 0;
  logic [ROB_W-1:0]  rob_num_dp = '0, rob_num_rec = '0;
  logic [PREG_W-1:0] p_rd_new = '0, p_rs = '0, p_rt = '0, p_rd_compl = '0;
  logic [IMM_W-1:0]  immed = '0;
  logic [PREG_W-1:0] p_rs_out, p_rt_out, p_rd_out;
  logic [IMM_W-1:0]  immed_out;
  logic [ROB_W-1:0]  rob_num_out;
  logic RegDest_out, mem_ren_out, mem_wen_out, issue, lss_full, lss_empty;
  logic [$clog2(DEPTH):0] lss_count;

  ls_issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst), .isDispatch(isDispatch), .rob_num_dp(rob_num_dp),
    .p_rd_new(p_rd_new), .p_rs(p_rs), .read_rs(read_rs), .v_rs(v_rs),
    .p_rt(p_rt), .read_rt(read_rt), .v_rt(v_rt), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .immed(immed), .stall_hazard(stall_hazard), .issue_ready(issue_ready),
    .recover(recover), .rob_num_rec(rob_num_rec), .p_rd_compl(p_rd_compl),
    .RegDest_compl(RegDest_compl), .complete(complete),
    .p_rs_out(p_rs_out), .p_rt_out(p_rt_out), .p_rd_out(p_rd_out), .immed_out(immed_out),
    .rob_num_out(rob_num_out), .RegDest_out(RegDest_out), .mem_ren_out(mem_ren_out),
    .mem_wen_out(mem_wen_out), .issue(issue), .lss_full(lss_full), .lss_empty(lss_empty),
    .lss_count(lss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rob, rd, rs, rt, imm;
    bit lw, st, rdy_rs, rdy_rt, killed;
  } mrec_t;

  mrec_t mq[$];   // model of queue contents, program order
  mrec_t sb[$];   // expected issues, program order
  int total = 0, bad = 0, n_issued = 0;
  bit exp_issue = 0, exp_drain = 0, exp_write = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: flags every cycle, payload popped from the scoreboard on each issue.
  always @(negedge clk) begin
    mrec_t e;
    chk("issue", 32'(issue), 32'(exp_issue));
    chk("count", 32'(lss_count), 32'(mq.size()));
    chk("full", 32'(lss_full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(lss_empty), 32'(mq.size() == 0));
    if (issue === 1'b1) begin
      n_issued++;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow act=issue exp=no_issue t=%0t", $time);
      end else begin
        e = sb.pop_front();
        $display("issue rob=%0d rd=%0d rs=%0d rt=%0d imm=%0h lw=%0d st=%0d t=%0t",
                 rob_num_out, p_rd_out, p_rs_out, p_rt_out, immed_out, mem_ren_out, mem_wen_out, $time);
        chk("rob", 32'(rob_num_out), 32'(e.rob));
        chk("rd", 32'(p_rd_out), 32'(e.rd));
        chk("rs", 32'(p_rs_out), 32'(e.rs));
        chk("rt", 32'(p_rt_out), 32'(e.rt));
        chk("imm", 32'(immed_out), 32'(e.imm));
        chk("ren", 32'(mem_ren_out), 32'(e.lw));
        chk("wen", 32'(mem_wen_out), 32'(e.st));
        chk("regdest", 32'(RegDest_out), 32'(e.lw));
      end
    end
  end

  // Evaluate the queue rules for the current inputs, then advance one clock.
  task automatic step();
    bit wk;
    mrec_t n;
    exp_write = rst && isDispatch && !stall_hazard && (mq.size() < DEPTH) && !recover
                && (mem_ren || mem_wen);
    exp_issue = 0;
    exp_drain = 0;
    if (rst && mq.size() > 0) begin
      exp_issue = !recover && !stall_hazard && issue_ready && !mq[0].killed
                  && mq[0].rdy_rs && mq[0].rdy_rt;
      exp_drain = mq[0].killed && !recover;
    end
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      sb.delete();
    end else begin
      wk = complete && RegDest_compl;
      foreach (mq[i]) begin
        if (wk && mq[i].rs == int'(p_rd_compl)) mq[i].rdy_rs = 1;
        if (wk && mq[i].rt == int'(p_rd_compl)) mq[i].rdy_rt = 1;
        if (recover && mq[i].rob == int'(rob_num_rec)) begin
          mq[i].killed = 1; mq[i].lw = 0; mq[i].st = 0;
        end
      end
      if (recover)
        for (int i = sb.size() - 1; i >= 0; i--)
          if (sb[i].rob == int'(rob_num_rec)) sb.delete(i);
      if (exp_issue || exp_drain) void'(mq.pop_front());
      if (exp_write) begin
        n.rob = rob_num_dp; n.rd = p_rd_new; n.rs = p_rs; n.rt = p_rt; n.imm = immed;
        n.lw = mem_ren; n.st = mem_wen; n.killed = 0;
        n.rdy_rs = v_rs || !read_rs || (wk && p_rs == p_rd_compl);
        n.rdy_rt = v_rt || !read_rt || (wk && p_rt == p_rd_compl);
        mq.push_back(n);
        sb.push_back(n);
      end
    end
    #1;
  endtask

  task automatic idle();
    isDispatch = 0; mem_ren = 0; mem_wen = 0; stall_hazard = 0;
    recover = 0; complete = 0; RegDest_compl = 0;
  endtask

  task automatic disp(input bit lw, input int rob, input int rd, input int rs, input bit rrs,
                      input bit vrs, input int rt, input bit rrt, input bit vrt, input int imm);
    isDispatch = 1; mem_ren = lw; mem_wen = !lw;
    rob_num_dp = ROB_W'(rob); p_rd_new = PREG_W'(rd); immed = IMM_W'(imm);
    p_rs = PREG_W'(rs); read_rs = rrs; v_rs = vrs;
    p_rt = PREG_W'(rt); read_rt = rrt; v_rt = vrt;
  endtask

  task automatic wake(input int tag, input bit rd);
    complete = 1; RegDest_compl = rd; p_rd_compl = PREG_W'(tag);
  endtask

  task automatic expect_now(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    chk(name, act_sel, exp);
  endtask

  initial begin
    int base, rob_ctr;
    idle();
    rst = 0;
    step(); step();
    chk("rst_count", 32'(lss_count), 0);
    chk("rst_empty", 32'(lss_empty), 1);
    rst = 1;
    step();

    // Reset mid-operation with 3 entries held.
    issue_ready = 0;
    for (int i = 0; i < 3; i++) begin disp(1, i, 40 + i, 30, 1, 0, 0, 0, 0, i); step(); end
    idle();
    chk("held3", 32'(lss_count), 3);
    rst = 0; mq.delete(); sb.delete();
    step();
    chk("midrst_count", 32'(lss_count), 0);
    chk("midrst_empty", 32'(lss_empty), 1);
    chk("midrst_issue", 32'(issue), 0);
    rst = 1;
    issue_ready = 1;
    disp(1, 9, 11, 1, 1, 1, 2, 1, 1, 16'h55aa); step();
    idle(); step(); step();

    // Fill, drop a 9th, then drain in ROB order with head wrap.
    issue_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin disp(1, i, i + 1, i + 2, 1, 1, i + 3, 1, 1, 100 + i); step(); end
    chk("full", 32'(lss_full), 1);
    disp(1, 8, 9, 9, 1, 1, 9, 1, 1, 999); step();
    idle();
    chk("full_drop", 32'(lss_count), DEPTH);
    base = n_issued;
    issue_ready = 1;
    for (int i = 0; i < DEPTH; i++) step();
    chk("issued8", 32'(n_issued - base), DEPTH);
    chk("empty_after", 32'(lss_empty), 1);

    // Dispatch-cycle wakeup bypass.
    disp(1, 10, 20, 12, 1, 0, 0, 0, 0, 7); wake(12, 1); step();
    idle(); #1 expect_now("bypass_issue", 32'(issue), 1); step();

    // Store waits for both completions; RegDest_compl=0 does not wake.
    disp(0, 11, 0, 5, 1, 0, 9, 1, 0, 3); step();
    idle(); #1 expect_now("st_wait0", 32'(issue), 0); step();
    wake(9, 1); step();
    idle(); wake(5, 0); step();
    idle(); #1 expect_now("st_nowake", 32'(issue), 0); step();
    wake(5, 1); step();
    idle(); #1 expect_now("st_issue", 32'(issue), 1); step();

    // Recovery squashes rob 3; it drains silently then rob 4 issues.
    for (int i = 3; i <= 5; i++) begin disp(1, i, i, 20, 1, 0, 0, 0, 0, i); step(); end
    idle();
    chk("rec_cnt3", 32'(lss_count), 3);
    recover = 1; rob_num_rec = 3; step();
    idle(); chk("rec_hold", 32'(lss_count), 3);
    #1 expect_now("drain_noissue", 32'(issue), 0); step();
    chk("rec_cnt2", 32'(lss_count), 2);
    wake(20, 1); step();
    idle(); #1 expect_now("rob4_issue", 32'(issue), 1); step();
    chk("rec_cnt1", 32'(lss_count), 1);
    step();

    // Simultaneous write and issue, then stall.
    issue_ready = 0;
    for (int i = 0; i < 4; i++) begin disp(i % 2 == 0, 12 + i, i, i, 1, 1, i, 1, 1, i); step(); end
    issue_ready = 1;
    disp(1, 0, 1, 1, 1, 1, 1, 1, 1, 77); #1 expect_now("wi_issue", 32'(issue), 1); step();
    chk("wi_count", 32'(lss_count), 4);
    disp(1, 1, 1, 1, 1, 1, 1, 1, 1, 78); stall_hazard = 1;
    #1 expect_now("stall_issue", 32'(issue), 0); step();
    chk("stall_count", 32'(lss_count), 4);
    idle();
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic.
    rob_ctr = 0;
    for (int c = 0; c < 3000; c++) begin
      isDispatch = ($urandom_range(0, 9) < 6);
      mem_ren = $urandom_range(0, 1); mem_wen = ($urandom_range(0, 7) == 0) ? 1'b0 : !mem_ren;
      rob_num_dp = ROB_W'(rob_ctr); rob_ctr = (rob_ctr + 1) % 16;
      p_rd_new = PREG_W'($urandom_range(0, 63)); immed = IMM_W'($urandom());
      p_rs = PREG_W'($urandom_range(0, 15)); read_rs = $urandom_range(0, 1); v_rs = ($urandom_range(0, 3) == 0);
      p_rt = PREG_W'($urandom_range(0, 15)); read_rt = $urandom_range(0, 1); v_rt = ($urandom_range(0, 3) == 0);
      stall_hazard = ($urandom_range(0, 9) == 0);
      issue_ready = ($urandom_range(0, 9) < 7);
      recover = ($urandom_range(0, 19) == 0);
      if (mq.size() > 0) rob_num_rec = ROB_W'(mq[$urandom_range(0, mq.size() - 1)].rob);
      else rob_num_rec = ROB_W'($urandom_range(0, 15));
      complete = ($urandom_range(0, 9) < 4); RegDest_compl = ($urandom_range(0, 4) != 0);
      p_rd_compl = PREG_W'($urandom_range(0, 15));
      step();
    end

    // Flush: wake every tag, then let the queue empty.
    idle(); issue_ready = 1;
    for (int t = 0; t < 64; t++) begin wake(t, 1); step(); end
    idle();
    for (int i = 0; i < 20; i++) step();
    chk("final_sb", 32'(sb.size()), 0);
    chk("final_empty", 32'(lss_empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ls_issue_queue.md
Name: ls_issue_queue

Overview:
Parametrised in-order load/store issue queue; next generation of the 4-entry LS station in the OoO pipe. Accepts load/store instructions from dispatch and wakes operands from the CDB/complete broadcast. Issues the head entry to the LSQ/AGU in program order under a downstream ready handshake. Recovery squashes entries by ROB tag; squashed entries drain from the head without issuing. Adds dispatch-cycle wakeup bypass and occupancy reporting.

Parameters:
DEPTH, 8, number of entries; power of 2, minimum 2
PREG_W, 6, physical register tag width
ROB_W, 4, ROB index width
IMM_W, 16, immediate width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
isDispatch  in  1  dispatch slot valid
rob_num_dp  in  ROB_W  ROB tag of dispatching instruction
p_rd_new  in  PREG_W  destination preg (rt for loads)
p_rs  in  PREG_W  source preg rs
read_rs  in  1  rs is read
v_rs  in  1  rs ready per map table
p_rt  in  PREG_W  source preg rt
read_rt  in  1  rt is read
v_rt  in  1  rt ready per map table
mem_ren  in  1  load
mem_wen  in  1  store
immed  in  IMM_W  offset
stall_hazard  in  1  global stall
issue_ready  in  1  downstream can accept issue this cycle
recover  in  1  branch/jump recovery
rob_num_rec  in  ROB_W  ROB tag to squash
p_rd_compl  in  PREG_W  completing preg
RegDest_compl  in  1  completion writes a register
complete  in  1  completion valid
p_rs_out  out  PREG_W  head rs
p_rt_out  out  PREG_W  head rt
p_rd_out  out  PREG_W  head rd
immed_out  out  IMM_W  head immediate
rob_num_out  out  ROB_W  head ROB tag
RegDest_out  out  1  head is load
mem_ren_out  out  1  head is load
mem_wen_out  out  1  head is store
issue  out  1  head issued this cycle
lss_full  out  1  count == DEPTH
lss_empty  out  1  count == 0
lss_count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst=0): all entries invalid and cleared; head=tail=0; count=0; issue=0, lss_full=0, lss_empty=1, lss_count=0, all head payload outputs 0.
- Entry: valid, killed, isLW, isST, rob, rd, rs, rdy_rs, rt, rdy_rt, imm. Circular buffer; head/tail are log2(DEPTH)-bit pointers that wrap DEPTH-1 -> 0.
- write = isDispatch & !stall_hazard & !lss_full & !recover & (mem_ren|mem_wen). Entry written at tail; tail++ next edge. lss_full blocks write even if a pop occurs the same cycle.
- Initial readiness: rdy_rs = v_rs | !read_rs | wk_rs; wk_rs = complete & RegDest_compl & (p_rd_compl==p_rs). Same rule for rt. Bypass prevents a missed wakeup on the dispatch cycle.
- Wakeup: each valid, non-written entry with complete & RegDest_compl & tag match sets its rdy bit; rs and rt are independent; the same tag may wake both.
- Recover: every valid entry with rob==rob_num_rec sets killed=1 and clears isLW/isST. Write, issue and drain are all blocked that cycle.
- Issue: issue = !recover & !stall_hazard & issue_ready & head valid & !killed & rdy_rs & rdy_rt. Outputs are combinational from the head entry (0-cycle latency). Downstream samples them when issue=1; head clears and advances next edge.
- Drain: head valid & killed & !recover pops the head without asserting issue, independent of stall_hazard and issue_ready. At most one pop (issue or drain) per cycle.
- Count: +1 on write, -1 on pop, unchanged on both. lss_full, lss_empty and lss_count derive from the registered count.
- Stall or !issue_ready holds the head unchanged; wakeups continue.
- Empty: issue=0; payload outputs show the stale head slot; ignore them.
- mem_ren=mem_wen=0 with isDispatch: no write.

Test Plan:
- Reset mid-operation with 3 entries held -> next cycle lss_count=0, lss_empty=1, issue=0. A dispatch afterwards lands in slot 0.
- Dispatch 8 loads with v_rs=v_rt=1, issue_ready=0 -> lss_full=1 and a 9th dispatch is dropped. Set issue_ready=1 -> 8 consecutive issues in ROB order 0..7, with head wrap verified.
- Load with p_rs=12, v_rs=0, read_rt=0, dispatched while complete=1, RegDest_compl=1, p_rd_compl=12 -> issues the next cycle without another wakeup.
- Store rs=5, rt=9, both not ready. Complete tag 9, then tag 5 -> issue only after the second completion. RegDest_compl=0 with tag 5 -> no wakeup.
- Entries rob 3,4,5 queued not ready; recover with rob_num_rec=3 -> head drains in 1 cycle with issue=0, then rob 4 issues once ready; lss_count 3->2->1.
- Simultaneous write and issue with count=4 -> count stays 4, tail and head both advance. stall_hazard=1 -> neither write nor issue occurs.
